parity_err_ctrl: RTL
====================

Name: parity_err_ctrl

Overview:
- Controller for the bus-interface parity generator/checker.
- Drives per-channel check enables (ENERR) and fault-injection pulses (FIERR).
- Aggregates per-channel parity mismatches into sticky status, a saturating error counter and a dual-rail ERR/ERR_B alarm.
- Runs a self-test sequencer: injects a fault on one channel, confirms the checker detects it, and reports pass/fail without raising the functional alarm.

Parameters:
- NUM_CH, 4, number of parity-protected channels (ch0 WADDR, ch1 WDATA, ch2 RADDR, ch3 RDATA).
- CNT_W, 8, width of the error counter.
- INJ_TIMEOUT, 16, cycles allowed from injection arm to detection (minimum 2).

Ports:
- ACLK  in  1  clock.
- RESETN_ACLK  in  1  reset, asynchronous, active-low.
- CH_VALID  in  NUM_CH  per-channel beat valid.
- CH_PERR  in  NUM_CH  raw checker mismatch per channel; meaningful only with CH_VALID.
- CFG_EN  in  NUM_CH  software check enable per channel.
- ENERR  out  NUM_CH  registered CFG_EN, sent to the parity block.
- FIERR  out  NUM_CH  fault-inject request to the parity block.
- INJ_REQ  in  1  self-test request; requester holds it high until INJ_ACK.
- INJ_CH  in  clog2(NUM_CH)  channel to test; captured when the request is accepted.
- INJ_ACK  out  1  one-cycle pulse: self-test done.
- INJ_PASS  out  1  result, valid while INJ_ACK=1; holds its value until the next INJ_ACK.
- CLR_REQ  in  1  clear-status pulse.
- CLR_ACK  out  1  one-cycle pulse, one cycle after CLR_REQ.
- ERR_STATUS  out  NUM_CH  sticky per-channel error flags.
- ERR_CNT  out  CNT_W  saturating count of error cycles.
- ERR_FIRST  out  clog2(NUM_CH)  lowest-index channel of the first error since the last clear.
- ERR  out  1  alarm, true-rail.
- ERR_B  out  1  alarm, complement rail.

Behaviour:
- Reset values: ENERR=0, FIERR=0, INJ_ACK=0, INJ_PASS=0, CLR_ACK=0, ERR_STATUS=0, ERR_CNT=0, ERR_FIRST=0, ERR=0, ERR_B=1; FSM in IDLE.
- Reset asserted mid-test: FIERR drops immediately; no INJ_ACK is issued.
- ENERR = CFG_EN delayed 1 cycle.
- Functional error detection:
  - hit[i] = CH_VALID[i] & CH_PERR[i] & ENERR[i] & ~mask[i].
  - mask[i]=1 only while the FSM is in ARM or WAIT with cap_ch==i.
- Status latency: hit in cycle N -> ERR_STATUS[i] set at edge N+1.
- ERR = registered OR of ERR_STATUS, so ERR rises at edge N+2. ERR_B = ~ERR, both driven from a single register pair. ERR and ERR_B are never equal outside reset.
- ERR_CNT: +1 per cycle in which any hit is set, regardless of how many channels hit. Saturates at 2^CNT_W-1 with no wrap.
- ERR_FIRST: loaded with the lowest-index hit only when ERR_STATUS==0 before the edge.
- Clear:
  - CLR_REQ in cycle N zeroes ERR_STATUS, ERR_CNT and ERR_FIRST at edge N+1; CLR_ACK is high in cycle N+1.
  - Simultaneous clear and hit: the hit wins. Status shows only the new hits, ERR_CNT=1, ERR_FIRST=new channel.
- Self-test FSM, states IDLE, ARM, WAIT, DONE:
  - IDLE: INJ_REQ=1 captures cap_ch=INJ_CH, resets the timer to 0, and moves to ARM. If ENERR[INJ_CH]=0 at acceptance, go to DONE with pass=0.
  - ARM: FIERR[cap_ch]=1. When CH_VALID[cap_ch]=1 (the corrupted beat), move to WAIT; FIERR drops next cycle.
  - WAIT: CH_PERR[cap_ch]&CH_VALID[cap_ch] -> DONE with pass=1.
  - Timeout: the timer counts in ARM and WAIT. Reaching INJ_TIMEOUT -> DONE with pass=0, FIERR=0.
  - DONE: INJ_ACK=1 for one cycle, INJ_PASS=pass, then IDLE. A new request is accepted only once INJ_REQ has been low for at least 1 cycle.
- INJ_REQ outside IDLE is ignored. INJ_CH >= NUM_CH -> DONE with pass=0.
- Errors on non-tested channels during a self-test are counted normally.
- FIERR is one-hot or zero at all times.

Decomposition:
- Package parity_ctrl_pkg holds:
  - FSM state enum (IDLE/ARM/WAIT/DONE).
  - Function clog2 for the index widths.
  - Default channel-index constants CH_WADDR=0, CH_WDATA=1, CH_RADDR=2, CH_RDATA=3.
- One sub-module, parity_inj_seq, holds the self-test FSM, timer, FIERR and mask generation.
- Status, counter and dual-rail alarm logic stays in the top module.

Test Plan:
- Reset release with no traffic -> ERR=0, ERR_B=1, ERR_CNT=0, ENERR=0. CFG_EN=4'hF -> ENERR=4'hF one cycle later.
- Ch1 valid+perr for 3 consecutive cycles -> ERR_STATUS=4'b0010, ERR_CNT=3, ERR_FIRST=1. ERR rises 2 cycles after the first hit; ERR_B falls in the same cycle.
- Ch2 and ch3 hit in the same cycle -> ERR_FIRST=2, ERR_CNT=1. Then 300 further ch3 hit cycles -> ERR_CNT stays at 255.
- CLR_REQ in the same cycle as a ch0 hit -> CLR_ACK next cycle; ERR_STATUS=4'b0001, ERR_CNT=1, ERR_FIRST=0.
- INJ_REQ with INJ_CH=2 and ch2 enabled; beat 3 cycles later; CH_PERR returned -> FIERR[2] high until the beat, INJ_ACK with INJ_PASS=1. ERR_STATUS stays 0 and ERR stays 0.
- INJ_REQ on ch0 with no detection -> INJ_ACK with INJ_PASS=0 exactly INJ_TIMEOUT=16 cycles after acceptance. Repeat with ENERR[0]=0 -> immediate fail. Assert reset while in ARM -> FIERR drops immediately and no INJ_ACK is issued.

Source files
------------

// File: rtl/parity_ctrl_pkg.sv
// Shared types and helpers for the bus-interface parity controller.
package parity_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } inj_state_e;

  localparam int unsigned CH_WADDR = 0;
  localparam int unsigned CH_WDATA = 1;
  localparam int unsigned CH_RADDR = 2;
  localparam int unsigned CH_RDATA = 3;

  // Index width for n items; never below 1 so single-channel builds still have a port.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/parity_inj_seq.sv
// Self-test sequencer: arms a fault injection on one channel and waits for the checker to flag it.
module parity_inj_seq
  import parity_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned INJ_TIMEOUT = 16,
  localparam int unsigned IDX_W      = clog2(NUM_CH)
) (
  input  logic              ACLK,
  input  logic              RESETN_ACLK,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_perr,
  input  logic [NUM_CH-1:0] enerr,
  input  logic              inj_req,
  input  logic [IDX_W-1:0]  inj_ch,
  output logic [NUM_CH-1:0] fierr,
  output logic              inj_ack,
  output logic              inj_pass,
  output logic [NUM_CH-1:0] mask_c
);

  localparam int unsigned TMR_W = clog2(INJ_TIMEOUT);

  inj_state_e        state;
  logic [IDX_W-1:0]  cap_ch;
  logic [TMR_W-1:0]  timer;
  logic              wait_low;
  logic [NUM_CH-1:0] req_oh;
  logic [NUM_CH-1:0] cap_oh;
  logic              req_ok;
  logic              cap_valid;
  logic              cap_perr;
  logic              timer_hit;

  // An out-of-range request channel shifts to zero, so it fails the enable test.
  assign req_oh    = NUM_CH'(1) << inj_ch;
  assign cap_oh    = NUM_CH'(1) << cap_ch;
  assign req_ok    = |(enerr & req_oh);
  assign cap_valid = |(ch_valid & cap_oh);
  assign cap_perr  = |(ch_perr & cap_oh);
  assign timer_hit = (timer == TMR_W'(INJ_TIMEOUT - 1));
  assign mask_c    = (state == ARM || state == WAIT) ? cap_oh : '0;

  always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
    if (!RESETN_ACLK) begin
      state    <= IDLE;
      cap_ch   <= '0;
      timer    <= '0;
      wait_low <= 1'b0;
      fierr    <= '0;
      inj_ack  <= 1'b0;
      inj_pass <= 1'b0;
    end else begin
      inj_ack <= 1'b0;
      // After an acknowledge the requester must drop its request before the next one counts.
      if (state == DONE) wait_low <= 1'b1;
      else if (!inj_req) wait_low <= 1'b0;

      unique case (state)
        IDLE: begin
          if (inj_req && !wait_low) begin
            cap_ch <= inj_ch;
            timer  <= '0;
            if (req_ok) begin
              state <= ARM;
              fierr <= req_oh;
            end else begin
              state    <= DONE;
              inj_ack  <= 1'b1;
              inj_pass <= 1'b0;
            end
          end
        end
        ARM: begin
          timer <= timer + TMR_W'(1);
          if (timer_hit) begin
            state    <= DONE;
            fierr    <= '0;
            inj_ack  <= 1'b1;
            inj_pass <= 1'b0;
          end else if (cap_valid) begin
            state <= WAIT;
            fierr <= '0;
          end
        end
        WAIT: begin
          timer <= timer + TMR_W'(1);
          if (cap_valid && cap_perr) begin
            state    <= DONE;
            inj_ack  <= 1'b1;
            inj_pass <= 1'b1;
          end else if (timer_hit) begin
            state    <= DONE;
            inj_ack  <= 1'b1;
            inj_pass <= 1'b0;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parity_err_ctrl.sv
// Parity controller: check enables, sticky error status, saturating counter and dual-rail alarm.
module parity_err_ctrl
  import parity_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned INJ_TIMEOUT = 16,
  localparam int unsigned IDX_W      = clog2(NUM_CH)
) (
  input  logic              ACLK,
  input  logic              RESETN_ACLK,
  input  logic [NUM_CH-1:0] CH_VALID,
  input  logic [NUM_CH-1:0] CH_PERR,
  input  logic [NUM_CH-1:0] CFG_EN,
  output logic [NUM_CH-1:0] ENERR,
  output logic [NUM_CH-1:0] FIERR,
  input  logic              INJ_REQ,
  input  logic [IDX_W-1:0]  INJ_CH,
  output logic              INJ_ACK,
  output logic              INJ_PASS,
  input  logic              CLR_REQ,
  output logic              CLR_ACK,
  output logic [NUM_CH-1:0] ERR_STATUS,
  output logic [CNT_W-1:0]  ERR_CNT,
  output logic [IDX_W-1:0]  ERR_FIRST,
  output logic              ERR,
  output logic              ERR_B
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] mask_c;
  logic [NUM_CH-1:0] hit;
  logic              any_hit;
  logic [IDX_W-1:0]  hit_low;

  parity_inj_seq #(
    .NUM_CH      (NUM_CH),
    .INJ_TIMEOUT (INJ_TIMEOUT)
  ) u_inj_seq (
    .ACLK        (ACLK),
    .RESETN_ACLK (RESETN_ACLK),
    .ch_valid    (CH_VALID),
    .ch_perr     (CH_PERR),
    .enerr       (ENERR),
    .inj_req     (INJ_REQ),
    .inj_ch      (INJ_CH),
    .fierr       (FIERR),
    .inj_ack     (INJ_ACK),
    .inj_pass    (INJ_PASS),
    .mask_c      (mask_c)
  );

  // The channel under self-test is masked so the injected fault never reaches status.
  assign hit     = CH_VALID & CH_PERR & ENERR & ~mask_c;
  assign any_hit = |hit;

  always_comb begin
    hit_low = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) hit_low = IDX_W'(i);
    end
  end

  // A clear coinciding with a hit restarts the history from that hit.
  always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
    if (!RESETN_ACLK) begin
      ENERR      <= '0;
      CLR_ACK    <= 1'b0;
      ERR_STATUS <= '0;
      ERR_CNT    <= '0;
      ERR_FIRST  <= '0;
      ERR        <= 1'b0;
      ERR_B      <= 1'b1;
    end else begin
      ENERR   <= CFG_EN;
      CLR_ACK <= CLR_REQ;
      ERR     <= |ERR_STATUS;
      ERR_B   <= ~(|ERR_STATUS);
      if (CLR_REQ) begin
        ERR_STATUS <= hit;
        ERR_CNT    <= CNT_W'(any_hit);
        ERR_FIRST  <= hit_low;
      end else begin
        ERR_STATUS <= ERR_STATUS | hit;
        if (any_hit && ERR_CNT != CNT_MAX) ERR_CNT <= ERR_CNT + CNT_W'(1);
        if (any_hit && ERR_STATUS == '0) ERR_FIRST <= hit_low;
      end
    end
  end

endmodule
